regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 101 ++++++++++
 tb/tb_regfile_mp.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with INIT sweep and busy scoreboard
// Optional write-to-read forwarding enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                busy_set_en,
  input  logic [AW-1:0]       busy_set_addr,
  output logic [NREGS-1:0]    busy,
  output logic                init_done
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic [NREGS-1:0]    busy_q, busy_d;
  logic                init_done_q, init_done_d;
  logic [XLEN-1:0]     regs_q [NREGS];
  logic [XLEN-1:0]     regs_d [NREGS];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    regs_d  = regs_q;
    if (state_q == ST_INIT) begin
      regs_d[cnt_q] = '0;
      cnt_d = cnt_q + AW'(1);
      if (cnt_q == AW'(NREGS - 1)) begin
        state_d = ST_RUN;
      end
    end else begin
      // Ascending port order lets the highest-index writer win a collision.
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
          regs_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
          busy_d[wr_addr[j*AW +: AW]] = 1'b0;
        end
      end
      if (busy_set_en && (busy_set_addr != '0)) begin
        busy_d[busy_set_addr] = 1'b1;
      end
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
    init_done_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= AW'(1);
      busy_q      <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
    end
  end

  // No reset on the array itself; the INIT sweep is the only clearing path.
  always_ff @(posedge clk) begin
    if (!rst) begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NRD; i++) begin
      if ((state_q == ST_RUN) && (rd_addr[i*AW +: AW] != '0)) begin
        rd_data[i*XLEN +: XLEN] = regs_q[rd_addr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < NWR; j++) begin
          if (!rst && wr_en[j] && (wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])) begin
            rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
          end
        end
`else
`endif
      end
    end
  end

  assign busy      = busy_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp
// Expectations follow REGFILE_BYPASS_EN when it is defined for the build.
module tb_regfile_mp;

  localparam int XLEN = 32, NREGS = 32, NRD = 2, NWR = 2, AW = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                busy_set_en;
  logic [AW-1:0]       busy_set_addr;
  logic [NREGS-1:0]    busy;
  logic                init_done;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr),
    .busy(busy), .init_done(init_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [XLEN-1:0]  m_mem [NREGS];
  logic [NREGS-1:0] m_busy;
  int               m_init_left;

  typedef struct {
    logic [1:0]      we;
    logic [AW-1:0]   wa0, wa1;
    logic [XLEN-1:0] wd0, wd1;
    logic [AW-1:0]   ra0, ra1;
    logic [XLEN-1:0] e0, e1;
  } vec_t;
  vec_t vt [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [XLEN-1:0] exp_rd(input int a);
    if (m_init_left > 0 || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (!rst) begin
      for (int j = NWR - 1; j >= 0; j--) begin
        if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) return wr_data[j*XLEN +: XLEN];
      end
    end
`endif
    return m_mem[a];
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_init_left = NREGS - 1;
      m_busy = '0;
      for (int k = 0; k < NREGS; k++) m_mem[k] = '0;
    end else if (m_init_left > 0) begin
      m_init_left--;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] != 0) begin
          m_mem[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
          m_busy[wr_addr[j*AW +: AW]] = 1'b0;
        end
      end
      if (busy_set_en && busy_set_addr != 0) m_busy[busy_set_addr] = 1'b1;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".init_done"}, 64'(init_done), 64'(m_init_left == 0));
    chk({tag, ".busy"}, 64'(busy), 64'(m_busy));
    for (int i = 0; i < NRD; i++)
      chk({tag, ".rd"}, 64'(rd_data[i*XLEN +: XLEN]), 64'(exp_rd(int'(rd_addr[i*AW +: AW]))));
  endtask

  task automatic run_cycle(input string tag);
    #1;
    check_outputs(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    busy_set_en = 1'b0; busy_set_addr = '0;
  endtask

  task automatic count_init(output int n);
    n = 0;
    while (init_done !== 1'b1 && n < 100) begin
      n++;
      run_cycle("init");
    end
  endtask

  int n_init;

  initial begin
    vt[0] = '{2'b11, 5'd5,  5'd5, 32'hDEADBEEF, 32'h12345678, 5'd5,  5'd5, 32'h12345678, 32'h12345678};
    vt[1] = '{2'b01, 5'd0,  5'd0, 32'hFFFFFFFF, 32'h0,        5'd0,  5'd0, 32'h0,        32'h0};
    vt[2] = '{2'b11, 5'd10, 5'd11, 32'h00001111, 32'h00002222, 5'd10, 5'd11, 32'h00001111, 32'h00002222};
    vt[3] = '{2'b11, 5'd31, 5'd0, 32'hCAFEF00D, 32'h99999999, 5'd31, 5'd0, 32'hCAFEF00D, 32'h0};
    vt[4] = '{2'b00, 5'd0,  5'd0, 32'h0,        32'h0,        5'd5,  5'd10, 32'h12345678, 32'h00001111};

    idle();
    rd_addr = '0;
    rst = 1'b1;
    @(posedge clk);
    model_edge();
    #1;
    rst = 1'b0;
    chk("reset.init_done", 64'(init_done), 64'd0);
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.rd", 64'(rd_data), 64'd0);

    count_init(n_init);
    chk("init_len", 64'(n_init), 64'd31);
    for (int a = 0; a < NREGS; a++) begin
      rd_addr = {AW'(a), AW'(NREGS - 1 - a)};
      #1;
      chk("first_run_rd", 64'(rd_data), 64'd0);
    end

    for (int v = 0; v < 5; v++) begin
      wr_en = vt[v].we;
      wr_addr = {vt[v].wa1, vt[v].wa0};
      wr_data = {vt[v].wd1, vt[v].wd0};
      rd_addr = {vt[v].ra1, vt[v].ra0};
      run_cycle("vec_wr");
      idle();
      #1;
      chk("vec_rd0", 64'(rd_data[0 +: XLEN]), 64'(vt[v].e0));
      chk("vec_rd1", 64'(rd_data[XLEN +: XLEN]), 64'(vt[v].e1));
      run_cycle("vec_rd");
    end

    busy_set_en = 1'b1; busy_set_addr = 5'd7;
    run_cycle("bset7");
    idle();
    chk("busy7_c1", 64'(busy[7]), 64'd1);
    run_cycle("bwait");
    chk("busy7_c2", 64'(busy[7]), 64'd1);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'h0, 32'h77};
    chk("busy7_c3", 64'(busy[7]), 64'd1);
    run_cycle("bwr7");
    idle();
    chk("busy7_clr", 64'(busy[7]), 64'd0);
    busy_set_en = 1'b1; busy_set_addr = 5'd9;
    wr_en = 2'b10; wr_addr = {5'd9, 5'd0}; wr_data = {32'h99, 32'h0};
    run_cycle("bset9");
    idle();
    chk("busy9_setwins", 64'(busy[9]), 64'd1);
    busy_set_en = 1'b1; busy_set_addr = 5'd0;
    run_cycle("bset0");
    idle();
    chk("busy_vec", 64'(busy), 64'h200);

    wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'h0BADCAFE};
    run_cycle("pre3");
    wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'hA5A5A5A5};
    rd_addr = {5'd3, 5'd3};
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("fwd_rd0", 64'(rd_data[0 +: XLEN]), 64'hA5A5A5A5);
    chk("fwd_rd1", 64'(rd_data[XLEN +: XLEN]), 64'hA5A5A5A5);
`else
    chk("nofwd_rd0", 64'(rd_data[0 +: XLEN]), 64'h0BADCAFE);
    chk("nofwd_rd1", 64'(rd_data[XLEN +: XLEN]), 64'h0BADCAFE);
`endif
    run_cycle("wr3");
    idle();
    #1;
    chk("after_rd0", 64'(rd_data[0 +: XLEN]), 64'hA5A5A5A5);
    chk("after_rd1", 64'(rd_data[XLEN +: XLEN]), 64'hA5A5A5A5);

    wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'h0, 32'h1};
    run_cycle("wr4");
    idle();
    rd_addr = {5'd4, 5'd4};
    #1;
    chk("x4_set", 64'(rd_data), {32'h1, 32'h1});
    rst = 1'b1;
    run_cycle("rst_a");
    rst = 1'b0;
    for (int k = 1; k < 10; k++) begin
      wr_en = 2'b11; wr_addr = {5'd4, 5'd4}; wr_data = {32'hFFFF0000, 32'h0000FFFF};
      busy_set_en = 1'b1; busy_set_addr = 5'd4;
      run_cycle("midinit");
      chk("midinit.done", 64'(init_done), 64'd0);
    end
    idle();
    rst = 1'b1;
    run_cycle("rst_b");
    rst = 1'b0;
    count_init(n_init);
    chk("reinit_len", 64'(n_init), 64'd31);
    chk("reinit_busy", 64'(busy), 64'd0);
    #1;
    chk("reinit_x4", 64'(rd_data), 64'd0);

    for (int c = 0; c < 400; c++) begin
      wr_en = 2'($urandom);
      for (int j = 0; j < NWR; j++) begin
        wr_addr[j*AW +: AW] = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
        wr_data[j*XLEN +: XLEN] = $urandom;
      end
      for (int i = 0; i < NRD; i++)
        rd_addr[i*AW +: AW] = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      busy_set_en = 1'($urandom);
      busy_set_addr = AW'($urandom_range(0, 7));
      rst = ($urandom_range(0, 199) == 0);
      run_cycle("rand");
    end
    rst = 1'b0;
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
